// File: rtl/phase_tag_pkg.sv
// Shared types, sizes and the frame checksum for the phase-tag UART streamer.
package phase_tag_pkg;

  localparam int unsigned TAG_W       = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned FRAME_BYTES = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned COUNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    CAPTURE,
    SEND
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } tag_t;

  function automatic logic [BYTE_W-1:0] frame_checksum(input logic [BYTE_W-1:0] sync,
                                                       input tag_t tag);
    return sync ^ tag.hi ^ tag.lo;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; accepts a new byte in the last stop-bit cycle so bytes chain gap-free.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CNT_W         = $clog2(CLKS_PER_BIT);
  localparam int unsigned BITS_PER_CHAR = 10;
  localparam int unsigned BIT_W         = 4;

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [8:0]       shreg;
  logic             bit_end;

  assign bit_end = active && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign done    = bit_end && (bit_cnt == BIT_W'(BITS_PER_CHAR - 1));

  // shreg holds data bits then the stop bit; ones shift in behind them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (start && (!active || done)) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (done) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else if (bit_end) begin
      baud_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
      tx       <= shreg[0];
      shreg    <= {1'b1, shreg[8:1]};
    end else if (active) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/phase_tag_uart_streamer.sv
// Pops 16-bit phase tags from the FIFO and sends each as a 4-byte framed 8N1 UART packet.
module phase_tag_uart_streamer
  import phase_tag_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Empty,
  input  logic [TAG_W-1:0]   fifo_q,
  input  logic               tx_enable,
  output logic               RdEn,
  output logic               tx,
  output logic               busy,
  output logic [COUNT_W-1:0] frames_sent
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  state_e               state_q, state_d;
  tag_t                 tag_q, tag_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rd_en_d, busy_d;
  logic [COUNT_W-1:0]   frames_d;
  logic                 uart_start_c, uart_done;
  logic [IDX_W-1:0]     byte_idx_c;
  logic [BYTE_W-1:0]    byte_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      RdEn        <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      RdEn        <= rd_en_d;
      busy        <= busy_d;
      frames_sent <= frames_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    rd_en_d      = 1'b0;
    busy_d       = busy;
    frames_d     = frames_sent;
    uart_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_enable && !Empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = POP;
        end
      end
      POP: state_d = CAPTURE;
      CAPTURE: begin
        // byte 0 is the constant sync byte, so it can start before the tag lands
        tag_d        = tag_t'(fifo_q);
        idx_d        = '0;
        uart_start_c = 1'b1;
        state_d      = SEND;
      end
      SEND: begin
        if (uart_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d        = idx_q + 1'b1;
            uart_start_c = 1'b1;
          end else begin
            frames_d = frames_sent + 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte presented to the serializer is the one it will load next
  always_comb begin
    byte_idx_c = (state_q == CAPTURE) ? '0 : IDX_W'(idx_q + 1'b1);
    byte_c     = SYNC_BYTE;
    case (byte_idx_c)
      2'd0:    byte_c = SYNC_BYTE;
      2'd1:    byte_c = tag_q.hi;
      2'd2:    byte_c = tag_q.lo;
      default: byte_c = frame_checksum(SYNC_BYTE, tag_q);
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .start(uart_start_c),
    .data (byte_c),
    .tx   (tx),
    .done (uart_done)
  );

endmodule

// File: tb/tb_phase_tag_uart_streamer.sv
// Self-checking bench: FIFO model, waveform-level UART receiver and frame reference model.
module tb_phase_tag_uart_streamer;

  localparam int unsigned CPB       = 4;
  localparam int unsigned CPB_SLOW  = 234;
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam int unsigned FRAME_CYC = 40 * CPB;

  typedef struct {
    logic [15:0] tag;
    logic [31:0] frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty = 1'b1;
  logic        tx_enable = 1'b0;
  logic [15:0] fifo_q = '0;
  logic        rd_en, tx, busy;
  logic [15:0] frames_sent;
  logic        s_empty = 1'b1;
  logic [15:0] s_fifo_q = '0;
  logic        s_rd_en, s_tx, s_busy;
  logic [15:0] s_frames;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] fifo[$];
  logic [15:0] s_fifo[$];
  logic [15:0] exp_tags[$];
  logic [31:0] rx_frames[$];
  vec_t        vecs[7];

  int ncyc = 0, rd_cnt = 0, busy_cyc = 0, tx_low_cyc = 0, t_rd = 0, t_tx = 0;
  int idle_run = 0, last_gap = 0, mon_t = 0, mon_err = 0;
  logic        mon_active = 1'b0;
  logic [31:0] mon_frame = '0;
  logic [31:0] mon_rx = '0;

  phase_tag_uart_streamer #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .Empty(empty), .fifo_q(fifo_q), .tx_enable(tx_enable),
    .RdEn(rd_en), .tx(tx), .busy(busy), .frames_sent(frames_sent));

  phase_tag_uart_streamer #(.CLKS_PER_BIT(CPB_SLOW), .SYNC_BYTE(SYNC)) dut_slow (
    .clk(clk), .rst_n(rst_n), .Empty(s_empty), .fifo_q(s_fifo_q), .tx_enable(tx_enable),
    .RdEn(s_rd_en), .tx(s_tx), .busy(s_busy), .frames_sent(s_frames));

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [15:0] tag);
    logic [7:0] hi, lo;
    hi = tag[15:8];
    lo = tag[7:0];
    return {SYNC, hi, lo, SYNC ^ hi ^ lo};
  endfunction

  // Ideal line level at cycle t of a frame: start, 8 data LSB first, stop, per byte
  function automatic logic wave_bit(input logic [31:0] frame, input int t, input int cpb);
    int bi, k, pos;
    logic [7:0] b;
    bi  = t / cpb;
    k   = bi / 10;
    pos = bi % 10;
    b   = frame[8*(3-k) +: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic push(input logic [15:0] t);
    fifo.push_back(t);
    exp_tags.push_back(t);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int start, k;
    start = rx_frames.size();
    k = 0;
    while (rx_frames.size() < start + n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(rx_frames.size() - start), 32'(n));
  endtask

  // FIFO models: data appears the cycle after the pop strobe
  initial forever begin
    @(posedge clk);
    if (rd_en) begin
      check("pop_nonempty", 32'(fifo.size() > 0), 32'd1);
      if (fifo.size() > 0) fifo_q <= fifo.pop_front();
    end
    if (s_rd_en && s_fifo.size() > 0) s_fifo_q <= s_fifo.pop_front();
  end

  // Negedge observer: flags, counters and the UART receiver for the fast instance
  initial forever begin
    @(negedge clk);
    ncyc++;
    empty   = (fifo.size() == 0);
    s_empty = (s_fifo.size() == 0);
    if (rd_en) begin
      rd_cnt++;
      t_rd = ncyc;
    end
    if (busy) busy_cyc++;
    if (!tx) tx_low_cyc++;
    if (!rst_n) begin
      mon_active = 1'b0;
      idle_run   = 0;
    end else begin
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
        mon_err    = 0;
        mon_rx     = '0;
        last_gap   = idle_run;
        idle_run   = 0;
        t_tx       = ncyc;
        check("frame_has_tag", 32'(exp_tags.size() > 0), 32'd1);
        mon_frame = (exp_tags.size() > 0) ? frame_of(exp_tags.pop_front()) : '0;
      end
      if (mon_active) begin
        if (tx !== wave_bit(mon_frame, mon_t, CPB)) mon_err++;
        if (mon_t % CPB == CPB / 2) begin
          int bi, pos, k;
          bi  = mon_t / CPB;
          pos = bi % 10;
          k   = bi / 10;
          if (pos >= 1 && pos <= 8) mon_rx[8*(3-k) + pos - 1] = tx;
        end
        mon_t++;
        if (mon_t == FRAME_CYC) begin
          check("frame_wave", 32'(mon_err), 32'd0);
          rx_frames.push_back(mon_rx);
          mon_active = 1'b0;
        end
      end else begin
        idle_run++;
      end
    end
  end

  initial begin
    logic [15:0] rtags[$];
    logic [15:0] t16;
    int n, k, s_err, base;
    vecs[0] = '{16'h1234, 32'hA512_3483};
    vecs[1] = '{16'h0000, 32'hA500_00A5};
    vecs[2] = '{16'hFFFF, 32'hA5FF_FFA5};
    vecs[3] = '{16'hBEEF, 32'hA5BE_EFF4};
    vecs[4] = '{16'h5AA5, 32'hA55A_A55A};
    vecs[5] = '{16'h0F0F, 32'hA50F_0FA5};
    vecs[6] = '{16'h8001, 32'hA580_0124};

    repeat (3) @(negedge clk);
    check("rst_rden", 32'(rd_en), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_slow_tx", 32'(s_tx), 32'd1);
    #2 rst_n = 1'b1;

    // Empty FIFO: no pops, line idle
    tx_enable = 1'b1;
    @(negedge clk);
    rd_cnt = 0;
    tx_low_cyc = 0;
    repeat (100) @(negedge clk);
    check("empty_no_rden", 32'(rd_cnt), 32'd0);
    check("empty_tx_idle", 32'(tx_low_cyc), 32'd0);

    for (int i = 0; i < 7; i++) begin
      rd_cnt = 0;
      busy_cyc = 0;
      push(vecs[i].tag);
      wait_frames(1, 400, $sformatf("vec%0d_frame_seen", i));
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_bytes", i), rx_frames[rx_frames.size()-1], vecs[i].frame);
      check($sformatf("vec%0d_rden_pulses", i), 32'(rd_cnt), 32'd1);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cyc), 32'(FRAME_CYC + 2));
      check($sformatf("vec%0d_frames_sent", i), 32'(frames_sent), 32'(i + 1));
      check($sformatf("vec%0d_busy_low", i), 32'(busy), 32'd0);
      if (i == 0) check("rden_to_start", 32'(t_tx - t_rd), 32'd2);
    end

    // tx_enable low blocks new frames; dropping it mid-frame does not cut the frame
    tx_enable = 1'b0;
    rd_cnt = 0;
    push(vecs[5].tag);
    repeat (50) @(negedge clk);
    check("disabled_no_rden", 32'(rd_cnt), 32'd0);
    check("disabled_frames", 32'(frames_sent), 32'd7);
    tx_enable = 1'b1;
    k = 0;
    while (!mon_active && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("enable_frame_started", 32'(mon_active), 32'd1);
    repeat (20) @(negedge clk);
    tx_enable = 1'b0;
    wait_frames(1, 400, "drop_enable_frame_seen");
    repeat (4) @(negedge clk);
    check("drop_enable_bytes", rx_frames[rx_frames.size()-1], vecs[5].frame);
    check("drop_enable_frames", 32'(frames_sent), 32'd8);
    tx_enable = 1'b1;

    // Back-to-back frames
    rd_cnt = 0;
    push(vecs[1].tag);
    push(vecs[2].tag);
    wait_frames(2, 800, "b2b_frames_seen");
    repeat (4) @(negedge clk);
    check("b2b_first", rx_frames[rx_frames.size()-2], vecs[1].frame);
    check("b2b_second", rx_frames[rx_frames.size()-1], vecs[2].frame);
    check("b2b_rden_pulses", 32'(rd_cnt), 32'd2);
    check("b2b_idle_gap", 32'(last_gap), 32'd3);

    // Reset during byte 2
    push(vecs[0].tag);
    k = 0;
    while (!(mon_active && mon_t > 20 * CPB) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("reset_in_byte2", 32'(mon_active && mon_t > 20 * CPB && mon_t <= 21 * CPB), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_frames", 32'(frames_sent), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tx_low_cyc = 0;
    rd_cnt = 0;
    repeat (30) @(negedge clk);
    check("post_rst_tx_idle", 32'(tx_low_cyc), 32'd0);
    check("post_rst_no_rden", 32'(rd_cnt), 32'd0);
    push(vecs[3].tag);
    wait_frames(1, 400, "post_rst_frame_seen");
    repeat (4) @(negedge clk);
    check("post_rst_bytes", rx_frames[rx_frames.size()-1], vecs[3].frame);
    check("post_rst_frames", 32'(frames_sent), 32'd1);

    // Random bursts against the frame model
    base = 1;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 3);
      rtags.delete();
      for (int j = 0; j < n; j++) begin
        t16 = 16'($urandom);
        rtags.push_back(t16);
        push(t16);
      end
      wait_frames(n, n * 200 + 50, $sformatf("rnd%0d_frames_seen", it));
      for (int j = 0; j < n; j++)
        check($sformatf("rnd%0d_%0d_bytes", it, j),
              rx_frames[rx_frames.size() - n + j], frame_of(rtags[j]));
      base += n;
      repeat ($urandom_range(4, 12)) @(negedge clk);
      check($sformatf("rnd%0d_frames_sent", it), 32'(frames_sent), 32'(base));
    end

    // Counter wrap from 0xFFFF
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    push(vecs[6].tag);
    wait_frames(1, 400, "wrap_frame_seen");
    repeat (4) @(negedge clk);
    check("wrap_bytes", rx_frames[rx_frames.size()-1], vecs[6].frame);
    check("wrap_frames_sent", 32'(frames_sent), 32'd0);

    // Full-rate baud: every cycle of the frame must match the ideal waveform
    s_fifo.push_back(vecs[3].tag);
    k = 0;
    while (s_tx !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("slow_start_seen", 32'(s_tx), 32'd0);
    s_err = 0;
    for (int t = 0; t < 40 * CPB_SLOW; t++) begin
      if (s_tx !== wave_bit(vecs[3].frame, t, CPB_SLOW)) s_err++;
      @(negedge clk);
    end
    check("slow_wave_errors", 32'(s_err), 32'd0);
    check("slow_tx_idle_after", 32'(s_tx), 32'd1);
    repeat (3) @(negedge clk);
    check("slow_frames_sent", 32'(s_frames), 32'd1);
    check("slow_busy_low", 32'(s_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
